// File: rtl/spi_host_master_pkg.sv
// spi_host_master_pkg: shared state encoding, default timing and SPI mode constants
package spi_host_master_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_CS_SETUP   = 1;
    localparam int DEF_CS_HOLD    = 1;
    localparam int TIMER_WIDTH    = 16;

    localparam bit SPI_CPOL       = 1'b0;
    localparam bit SPI_MSB_FIRST  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_WAIT     = 3'd4,
        ST_HOLD     = 3'd5
    } state_t;

endpackage

// File: rtl/spi_host_master_phase_timer.sv
// spi_phase_timer: loadable down-counter emitting a one-cycle done pulse on its final tick
module spi_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = cnt == W'(1);

    // Reload on request, otherwise count down to zero and rest there
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/spi_host_master.sv
// spi_host_master: mode-0 SPI initiator framing host bytes under a single chip-select assertion
module spi_host_master
    import spi_host_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_SETUP   = DEF_CS_SETUP,
    parameter int CS_HOLD    = DEF_CS_HOLD
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] TXData,
    input  logic                  TXValid,
    input  logic                  TXLast,
    output logic                  TXReady,
    output logic [DATA_WIDTH-1:0] RXData,
    output logic                  RXValid,
    output logic                  Busy,
    output logic                  _CS,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int BW = $clog2(DATA_WIDTH);

    state_t                  state;
    state_t                  next_state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [BW-1:0]           bit_cnt;
    logic                    last_q;
    logic                    accept;
    logic                    tmr_load;
    logic                    tmr_done;
    logic [TIMER_WIDTH-1:0]  tmr_val;

    assign TXReady = state == ST_IDLE || state == ST_WAIT;
    assign Busy    = state != ST_IDLE;
    assign accept  = TXValid && TXReady;

    spi_phase_timer #(.W(TIMER_WIDTH)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register
    always_ff @(posedge CLK) begin
        state <= RST ? ST_IDLE : next_state;
    end

    // Next state and phase-timer reload; WAIT needs no timer since it waits on the host
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = TIMER_WIDTH'(CLK_DIV);
        case (state)
            ST_IDLE: if (accept) begin
                next_state = ST_SETUP;
                tmr_load   = 1'b1;
                tmr_val    = TIMER_WIDTH'(CS_SETUP);
            end
            ST_SETUP: if (tmr_done) begin
                next_state = ST_SHIFT_LO;
                tmr_load   = 1'b1;
            end
            ST_SHIFT_LO: if (tmr_done) begin
                next_state = ST_SHIFT_HI;
                tmr_load   = 1'b1;
            end
            ST_SHIFT_HI: if (tmr_done) begin
                next_state = bit_cnt != '0 ? ST_SHIFT_LO : last_q ? ST_HOLD : ST_WAIT;
                tmr_load   = next_state != ST_WAIT;
                tmr_val    = next_state == ST_HOLD ? TIMER_WIDTH'(CS_HOLD) : TIMER_WIDTH'(CLK_DIV);
            end
            ST_WAIT: if (accept) begin
                next_state = ST_SHIFT_LO;
                tmr_load   = 1'b1;
            end
            ST_HOLD: if (tmr_done) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Serial pins, shift register and received byte; MISO enters the LSB as each SCLK rise is issued
    always_ff @(posedge CLK) begin
        if (RST) begin
            _CS     <= 1'b1;
            SCLK    <= SPI_CPOL;
            MOSI    <= 1'b0;
            RXData  <= '0;
            RXValid <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
        end else begin
            RXValid <= 1'b0;
            if (accept) begin
                shreg   <= TXData;
                last_q  <= TXLast;
                MOSI    <= TXData[DATA_WIDTH-1];
                _CS     <= 1'b0;
                bit_cnt <= BW'(DATA_WIDTH - 1);
            end
            if (state == ST_SHIFT_LO && tmr_done) begin
                SCLK  <= !SPI_CPOL;
                shreg <= {shreg[DATA_WIDTH-2:0], MISO};
            end
            if (state == ST_SHIFT_HI && tmr_done) begin
                SCLK <= SPI_CPOL;
                if (bit_cnt != '0) begin
                    MOSI    <= shreg[DATA_WIDTH-1];
                    bit_cnt <= bit_cnt - 1'b1;
                end else begin
                    RXData  <= shreg;
                    RXValid <= 1'b1;
                end
            end
            if (state == ST_HOLD && tmr_done)
                _CS <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed and randomized checks of the SPI host master against a byte-level model
module tb_spi_host_master;

    localparam int DW       = 8;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;

    logic [7:0] tx_data1 = '0;
    logic       tx_valid1 = 1'b0;
    logic       tx_last1 = 1'b0;
    logic       tx_ready1;
    logic [7:0] rx_data1;
    logic       rx_valid1;
    logic       busy1;
    logic       cs_n1;
    logic       sclk1;
    logic       mosi1;
    logic       miso1 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_host_master #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) u_dut (
        .CLK(clk), .RST(rst), .TXData(tx_data), .TXValid(tx_valid), .TXLast(tx_last), .TXReady(tx_ready),
        .RXData(rx_data), .RXValid(rx_valid), .Busy(busy), ._CS(cs_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    spi_host_master #(.DATA_WIDTH(DW), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut1 (
        .CLK(clk), .RST(rst), .TXData(tx_data1), .TXValid(tx_valid1), .TXLast(tx_last1), .TXReady(tx_ready1),
        .RXData(rx_data1), .RXValid(rx_valid1), .Busy(busy1), ._CS(cs_n1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1)
    );

    // Responder model: byte k of the frame goes out MSB first, advancing one bit per SCLK fall
    logic [7:0] resp [0:3];
    logic [7:0] frm  [0:3];
    int falls = 0;
    always @(negedge sclk or posedge cs_n) falls = cs_n ? 0 : falls + 1;
    assign miso = resp[(falls >> 3) & 3][7 - (falls & 7)];

    int cyc = 0;
    int acc_cyc = 0;
    int acc1 = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready && !rst) acc_cyc <= cyc + 1;
        if (tx_valid1 && tx_ready1 && !rst) acc1 <= cyc + 1;
    end

    logic [7:0] rx_q[$];
    int         lat_q[$];
    int         hold_q[$];
    logic       mosi_q[$];
    int         cs_rises = 0;
    int         rises = 0;
    int         fall_cyc = 0;
    int         viol = 0;
    logic       sclk_p = 1'b0;
    logic       cs_p = 1'b1;

    logic [7:0] rx1_q[$];
    int         lat1_q[$];
    int         r1_q[$];
    logic       m1_q[$];
    logic       sclk1_p = 1'b0;

    // Observe both DUTs away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            lat_q.push_back(cyc - acc_cyc);
        end
        if (sclk_p && !sclk) fall_cyc = cyc;
        if (!sclk_p && sclk) begin
            rises++;
            mosi_q.push_back(mosi);
        end
        if (!cs_p && cs_n && !rst) begin
            cs_rises++;
            hold_q.push_back(cyc - fall_cyc);
        end
        if (sclk && cs_n) viol++;
        sclk_p = sclk;
        cs_p = cs_n;
        if (rx_valid1) begin
            rx1_q.push_back(rx_data1);
            lat1_q.push_back(cyc - acc1);
        end
        if (!sclk1_p && sclk1) begin
            r1_q.push_back(cyc);
            m1_q.push_back(mosi1);
        end
        sclk1_p = sclk1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        rx_q.delete();
        lat_q.delete();
        hold_q.delete();
        mosi_q.delete();
        cs_rises = 0;
        rises = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        tx_data = d;
        tx_last = l;
        tx_valid = 1'b1;
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("accept_timeout", n, 0);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || !cs_n) && n < 1000);
        if (n >= 1000) chk("idle_timeout", n, 0);
        @(negedge clk);
    endtask

    // Byte-level expectations: MOSI per rise, responder bytes back, latency with SETUP only on a frame's first byte
    task automatic check_frame(input int n, input string tag);
        logic [7:0] b;
        chk({tag, "_rx_count"}, rx_q.size(), n);
        chk({tag, "_sclk_rises"}, mosi_q.size(), 8 * n);
        chk({tag, "_cs_rises"}, cs_rises, 1);
        chk({tag, "_cs_hold"}, hold_q.size() > 0 ? hold_q[0] : -1, CS_HOLD);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) b[7-j] = (8 * i + j < mosi_q.size()) ? mosi_q[8*i+j] : 1'bx;
            chk($sformatf("%s_mosi%0d", tag, i), b, frm[i]);
            chk($sformatf("%s_rx%0d", tag, i), i < rx_q.size() ? rx_q[i] : 8'hxx, resp[i]);
            chk($sformatf("%s_lat%0d", tag, i), i < lat_q.size() ? lat_q[i] : -1,
                (i == 0 ? CS_SETUP : 0) + 2 * DW * CLK_DIV);
        end
    endtask

    task automatic run_frame(input int n, input string tag);
        clear();
        for (int i = 0; i < n; i++) send(frm[i], i == n - 1);
        wait_idle();
        check_frame(n, tag);
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 4; i++) resp[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_txready", tx_ready, 1);
        chk("rst_rxvalid", rx_valid, 0);
        chk("rst_rxdata", rx_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        frm[0] = 8'hA5;
        resp[0] = 8'h3C;
        run_frame(1, "single");

        frm[0] = 8'h06; frm[1] = 8'h02; frm[2] = 8'hB7;
        for (int i = 0; i < 3; i++) resp[i] = 8'($urandom);
        run_frame(3, "regwr");

        clear();
        frm[0] = 8'($urandom); frm[1] = 8'($urandom);
        resp[0] = 8'($urandom); resp[1] = 8'($urandom);
        send(frm[0], 1'b0);
        n = 0;
        while (rx_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs_n !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        chk("wait_stall", bad, 0);
        send(frm[1], 1'b1);
        wait_idle();
        check_frame(2, "wait");

        clear();
        frm[0] = 8'($urandom); frm[1] = 8'($urandom);
        resp[0] = 8'($urandom); resp[1] = 8'($urandom);
        send(frm[0], 1'b0);
        n = 0;
        while (sclk !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_data = ~frm[0];
        tx_last = 1'b1;
        tx_valid = 1'b1;
        bad = 0;
        repeat (3) begin
            if (tx_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("busy_txready", bad, 0);
        send(frm[1], 1'b1);
        wait_idle();
        check_frame(2, "busy");

        clear();
        frm[0] = 8'hFF;
        resp[0] = 8'($urandom);
        send(frm[0], 1'b1);
        n = 0;
        while (rises < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs", cs_n, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_mosi", mosi, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_rxvalid", rx_q.size(), 0);
        frm[0] = 8'($urandom);
        resp[0] = 8'($urandom);
        run_frame(1, "post_rst");

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                frm[i] = 8'($urandom);
                resp[i] = 8'($urandom);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(n, $sformatf("rand%0d", r));
        end

        @(negedge clk);
        tx_data1 = 8'hFF;
        tx_last1 = 1'b1;
        tx_valid1 = 1'b1;
        @(posedge clk);
        #1 tx_valid1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy1 || !cs_n1) && n < 200);
        @(negedge clk);
        chk("div1_rx_count", rx1_q.size(), 1);
        chk("div1_rx", rx1_q.size() > 0 ? rx1_q[0] : 8'hxx, 8'h00);
        chk("div1_lat", lat1_q.size() > 0 ? lat1_q[0] : -1, 17);
        chk("div1_rises", r1_q.size(), 8);
        chk("div1_period", r1_q.size() == 8 ? r1_q[7] - r1_q[6] : -1, 2);
        bad = 0;
        foreach (m1_q[i]) if (m1_q[i] !== 1'b1) bad++;
        chk("div1_mosi", bad, 0);

        chk("cs_sclk_overlap", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
